// File: rtl/hb_interp2.sv
// hb_interp2: 2x halfband interpolator (15-tap prototype) with one time-shared multiplier.
// Define HB_INTERP_SAT_EN to saturate the even branch instead of wrapping.
module hb_interp2 (
    input  logic        sys_clk,
    input  logic        reset,
    input  logic        sys_clk2_en,
    input  logic        sam_clk_en,
    input  logic [17:0] x_in,
    output logic [17:0] y,
    output logic        y_phase,
    output logic        ovr_flag,
    output logic        udr_flag
);

    typedef enum logic [1:0] {S_IDLE, S_PRE, S_FLUSH1, S_FLUSH2} state_t;
    state_t state, state_nxt;

    logic               busy, accept, pre_en, commit;
    logic [1:0]         cnt;
    logic signed [17:0] d [8];
    logic [2:0]         idx_lo, idx_hi;
    logic signed [17:0] pre, coef;
    logic [1:0]         pre_k, prod_k;
    logic               pre_vld, prod_vld;
    logic signed [35:0] prod, acc, acc_sum;
    logic [17:0]        he, ho, y_even;
    logic               phase, fresh;
    logic               unused_bits;

    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:   if (sys_clk2_en) state_nxt = S_PRE;
            S_PRE:    if (cnt == 2'd3) state_nxt = S_FLUSH1;
            S_FLUSH1: state_nxt = S_FLUSH2;
            S_FLUSH2: state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy   = (state != S_IDLE);
        accept = sys_clk2_en && !busy;
        pre_en = (state == S_PRE);
    end

    always_comb begin
        idx_lo = {1'b0, cnt};
        idx_hi = 3'd7 - idx_lo;
        coef   = '0;
        case (pre_k)
            2'd0:    coef = -18'sd174;
            2'd1:    coef = 18'sd1637;
            2'd2:    coef = -18'sd7962;
            default: coef = 18'sd39267;
        endcase
        acc_sum = (prod_k == 2'd0) ? prod : acc + prod;
        commit  = prod_vld && (prod_k == 2'd3);
    end

    // he is taken from the final accumulate value so the commit lands at accept+6.
`ifdef HB_INTERP_SAT_EN
    always_comb begin
        if (acc_sum[35:32] != {4{acc_sum[32]}})
            y_even = acc_sum[35] ? 18'h20000 : 18'h1FFFF;
        else
            y_even = acc_sum[32:15];
        unused_bits = ^{x_in[0], acc_sum[14:0]};
    end
`else
    always_comb begin
        y_even      = acc_sum[32:15];
        unused_bits = ^{x_in[0], acc_sum[35:33], acc_sum[14:0]};
    end
`endif

    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            cnt      <= '0;
            for (int unsigned i = 0; i < 8; i++) d[i] <= '0;
            pre      <= '0;
            pre_k    <= '0;
            pre_vld  <= 1'b0;
            prod     <= '0;
            prod_k   <= '0;
            prod_vld <= 1'b0;
            acc      <= '0;
            he       <= '0;
            ho       <= '0;
        end else begin
            if (accept) begin
                d[0] <= {x_in[17], x_in[17:1]};
                for (int unsigned i = 1; i < 8; i++) d[i] <= d[i-1];
            end
            if (accept)      cnt <= '0;
            else if (pre_en) cnt <= cnt + 2'd1;
            pre_vld <= pre_en;
            if (pre_en) begin
                pre   <= d[idx_lo] + d[idx_hi];
                pre_k <= cnt;
            end
            prod_vld <= pre_vld;
            if (pre_vld) begin
                prod   <= 36'(pre) * 36'(coef);
                prod_k <= pre_k;
            end
            if (prod_vld) acc <= acc_sum;
            if (commit) begin
                he <= y_even;
                ho <= {d[3][16:0], 1'b0};
            end
        end
    end

    // fresh marks a pair committed since the last phase-0 output; commit wins over clear.
    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            y        <= '0;
            y_phase  <= 1'b0;
            phase    <= 1'b0;
            fresh    <= 1'b0;
            ovr_flag <= 1'b0;
            udr_flag <= 1'b0;
        end else begin
            if (sys_clk2_en && busy) ovr_flag <= 1'b1;
            if (commit)                     fresh <= 1'b1;
            else if (sam_clk_en && !phase)  fresh <= 1'b0;
            if (sam_clk_en) begin
                if (!phase) begin
                    y       <= he;
                    y_phase <= 1'b0;
                    phase   <= 1'b1;
                    if (!fresh) udr_flag <= 1'b1;
                end else begin
                    y       <= ho;
                    y_phase <= 1'b1;
                    phase   <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_hb_interp2.sv
// Self-checking bench for hb_interp2: scoreboard of expected outputs plus scenario tasks.
module tb_hb_interp2;

    logic        sys_clk = 1'b0;
    logic        reset = 1'b0;
    logic        sys_clk2_en = 1'b0;
    logic        sam_clk_en = 1'b0;
    logic [17:0] x_in = '0;
    logic [17:0] y;
    logic        y_phase, ovr_flag, udr_flag;

    int          total = 0;
    int          bad = 0;
    logic [18:0] sb[$];
    logic [18:0] sb_exp;
    bit          sb_on = 1'b0;
    int          md[8];
    int          h_e[8]      = '{-174, 1637, -7962, 39267, 39267, -7962, 1637, -174};
    int          imp_even[8] = '{-174, 1637, -7962, 39267, 39267, -7962, 1637, -174};

    hb_interp2 dut (
        .sys_clk     (sys_clk),
        .reset       (reset),
        .sys_clk2_en (sys_clk2_en),
        .sam_clk_en  (sam_clk_en),
        .x_in        (x_in),
        .y           (y),
        .y_phase     (y_phase),
        .ovr_flag    (ovr_flag),
        .udr_flag    (udr_flag)
    );

    always #5 sys_clk = ~sys_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Output monitor: each output strobe pops one expected {phase, value}.
    always @(posedge sys_clk) begin
        if (sb_on && sam_clk_en) begin
            #1;
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL sb_empty: got y=%0d phase=%0b, nothing expected", $signed(y), y_phase);
            end else begin
                sb_exp = sb.pop_front();
                if (y !== sb_exp[17:0] || y_phase !== sb_exp[18]) begin
                    bad++;
                    $display("FAIL sb_out: got y=%0d phase=%0b expected y=%0d phase=%0b",
                             $signed(y), y_phase, $signed(sb_exp[17:0]), sb_exp[18]);
                end
            end
        end
    end

    function automatic void model_clear();
        for (int i = 0; i < 8; i++) md[i] = 0;
    endfunction

    function automatic void model_push(input logic [17:0] xv);
        for (int i = 7; i > 0; i--) md[i] = md[i-1];
        md[0] = int'($signed(xv)) >>> 1;
    endfunction

    function automatic logic [17:0] model_even();
        longint a = 0;
        longint s;
        for (int i = 0; i < 8; i++) a += longint'(h_e[i]) * longint'(md[i]);
        s = a >>> 15;
`ifdef HB_INTERP_SAT_EN
        if (s > 131071) s = 131071;
        else if (s < -131072) s = -131072;
`endif
        return s[17:0];
    endfunction

    function automatic logic [17:0] model_odd();
        longint o = longint'(md[3]) * 2;
        return o[17:0];
    endfunction

    task automatic step(input logic en, input logic [17:0] xv, input logic sam);
        sys_clk2_en = en;
        x_in        = xv;
        sam_clk_en  = sam;
        @(posedge sys_clk);
        #1;
        sys_clk2_en = 1'b0;
        sam_clk_en  = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0);
    endtask

    // One 8-cycle frame: accept at cycle 0, odd of previous frame at cycle 3, even at cycle 7.
    task automatic run_frame(input logic [17:0] xv, input bit first,
                             input logic [17:0] ev, input logic [17:0] ov);
        sb.push_back({1'b0, ev});
        sb.push_back({1'b1, ov});
        for (int c = 0; c < 8; c++)
            step(c == 0, (c == 0) ? xv : 18'd0, (c == 7) || (c == 3 && !first));
    endtask

    task automatic drain();
        for (int c = 0; c < 4; c++) step(1'b0, '0, c == 3);
        idle(4);
    endtask

    task automatic do_reset();
        reset       = 1'b0;
        sys_clk2_en = 1'b0;
        sam_clk_en  = 1'b0;
        x_in        = '0;
        sb_on       = 1'b0;
        sb.delete();
        model_clear();
        repeat (2) @(posedge sys_clk);
        #1 reset = 1'b1;
    endtask

    task automatic run_impulse();
        for (int f = 0; f < 8; f++)
            run_frame((f == 0) ? 18'd65536 : 18'd0, f == 0, 18'(imp_even[f]),
                      (f == 3) ? 18'd65536 : 18'd0);
        drain();
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (y !== 18'd0) begin bad++; $display("FAIL reset_y: got %0d expected 0", $signed(y)); end
        total++; if (y_phase !== 1'b0) begin bad++; $display("FAIL reset_phase: got %0b expected 0", y_phase); end
        total++; if (ovr_flag !== 1'b0) begin bad++; $display("FAIL reset_ovr: got %0b expected 0", ovr_flag); end
        total++; if (udr_flag !== 1'b0) begin bad++; $display("FAIL reset_udr: got %0b expected 0", udr_flag); end
    endtask

    task automatic test_impulse();
        do_reset();
        sb_on = 1'b1;
        run_impulse();
        total++; if (sb.size() != 0) begin bad++; $display("FAIL impulse_drain: pending=%0d expected 0", sb.size()); end
        total++; if (ovr_flag !== 1'b0) begin bad++; $display("FAIL impulse_ovr: got %0b expected 0", ovr_flag); end
        total++; if (udr_flag !== 1'b0) begin bad++; $display("FAIL impulse_udr: got %0b expected 0", udr_flag); end
        sb_on = 1'b0;
    endtask

    task automatic test_dc();
        do_reset();
        sb_on = 1'b1;
        for (int f = 0; f < 12; f++) begin
            model_push(18'd131071);
            run_frame(18'd131071, f == 0, (f >= 7) ? 18'd131070 : model_even(),
                      (f >= 3) ? 18'd131070 : model_odd());
        end
        drain();
        total++; if (sb.size() != 0) begin bad++; $display("FAIL dc_drain: pending=%0d expected 0", sb.size()); end
        sb_on = 1'b0;
    endtask

    task automatic test_saturation();
        bit          neg[8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [17:0] xv, ev;
        do_reset();
        sb_on = 1'b1;
        for (int f = 0; f < 11; f++) begin
            xv = (f < 8) ? (neg[f] ? -18'sd131071 : 18'sd131071) : 18'd0;
            model_push(xv);
            ev = model_even();
`ifdef HB_INTERP_SAT_EN
            if (f == 7) ev = 18'sd131071;
`else
            if (f == 7) ev = -18'sd65987;
`endif
            run_frame(xv, f == 0, ev, model_odd());
        end
        drain();
        total++; if (sb.size() != 0) begin bad++; $display("FAIL sat_drain: pending=%0d expected 0", sb.size()); end
        sb_on = 1'b0;
    endtask

    task automatic test_overrun();
        do_reset();
        step(1'b1, 18'd65536, 1'b0);
        idle(2);
        step(1'b1, 18'd131071, 1'b0);
        total++; if (ovr_flag !== 1'b1) begin bad++; $display("FAIL ovr_set: got %0b expected 1", ovr_flag); end
        idle(3);
        step(1'b0, '0, 1'b1);
        total++; if ($signed(y) !== -174 || y_phase !== 1'b0) begin bad++; $display("FAIL ovr_even0: got %0d/%0b expected -174/0", $signed(y), y_phase); end
        step(1'b1, '0, 1'b0);
        idle(2);
        step(1'b0, '0, 1'b1);
        total++; if (y !== 18'd0 || y_phase !== 1'b1) begin bad++; $display("FAIL ovr_odd0: got %0d/%0b expected 0/1", $signed(y), y_phase); end
        idle(3);
        step(1'b0, '0, 1'b1);
        total++; if ($signed(y) !== 1637) begin bad++; $display("FAIL ovr_even1: got %0d expected 1637", $signed(y)); end
        total++; if (ovr_flag !== 1'b1) begin bad++; $display("FAIL ovr_sticky: got %0b expected 1", ovr_flag); end
        total++; if (udr_flag !== 1'b0) begin bad++; $display("FAIL ovr_udr: got %0b expected 0", udr_flag); end
        drain();
    endtask

    task automatic test_underrun();
        do_reset();
        step(1'b1, 18'd65536, 1'b0);
        idle(6);
        step(1'b0, '0, 1'b1);
        total++; if ($signed(y) !== -174) begin bad++; $display("FAIL udr_first: got %0d expected -174", $signed(y)); end
        total++; if (udr_flag !== 1'b0) begin bad++; $display("FAIL udr_early: got %0b expected 0", udr_flag); end
        idle(3);
        step(1'b0, '0, 1'b1);
        total++; if (y !== 18'd0 || y_phase !== 1'b1) begin bad++; $display("FAIL udr_odd: got %0d/%0b expected 0/1", $signed(y), y_phase); end
        idle(3);
        step(1'b0, '0, 1'b1);
        total++; if ($signed(y) !== -174 || y_phase !== 1'b0) begin bad++; $display("FAIL udr_repeat: got %0d/%0b expected -174/0", $signed(y), y_phase); end
        total++; if (udr_flag !== 1'b1) begin bad++; $display("FAIL udr_set: got %0b expected 1", udr_flag); end
        drain();
    endtask

    task automatic test_reset_mid();
        do_reset();
        sb_on = 1'b1;
        for (int f = 0; f < 4; f++) begin
            model_push(18'd131071);
            run_frame(18'd131071, f == 0, model_even(), model_odd());
        end
        model_push(18'd131071);
        sb.push_back({1'b0, model_even()});
        sb.push_back({1'b1, model_odd()});
        step(1'b1, 18'd131071, 1'b0);
        step(1'b1, 18'd131071, 1'b0);
        step(1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b1);
        total++; if (ovr_flag !== 1'b1 || y_phase !== 1'b1) begin bad++; $display("FAIL mid_pre: got ovr=%0b phase=%0b expected 1/1", ovr_flag, y_phase); end
        #2 reset = 1'b0;
        #1;
        total++; if (y !== 18'd0) begin bad++; $display("FAIL mid_y: got %0d expected 0", $signed(y)); end
        total++; if (y_phase !== 1'b0) begin bad++; $display("FAIL mid_phase: got %0b expected 0", y_phase); end
        total++; if (ovr_flag !== 1'b0 || udr_flag !== 1'b0) begin bad++; $display("FAIL mid_flags: got ovr=%0b udr=%0b expected 0/0", ovr_flag, udr_flag); end
        sb_on = 1'b0;
        sb.delete();
        model_clear();
        repeat (3) @(posedge sys_clk);
        #1 reset = 1'b1;
        idle(4);
        step(1'b0, '0, 1'b1);
        total++; if (y !== 18'd0 || y_phase !== 1'b0) begin bad++; $display("FAIL mid_nocommit_he: got %0d/%0b expected 0/0", $signed(y), y_phase); end
        idle(3);
        step(1'b0, '0, 1'b1);
        total++; if (y !== 18'd0 || y_phase !== 1'b1) begin bad++; $display("FAIL mid_nocommit_ho: got %0d/%0b expected 0/1", $signed(y), y_phase); end
        sb_on = 1'b1;
        run_impulse();
        total++; if (sb.size() != 0) begin bad++; $display("FAIL mid_impulse_drain: pending=%0d expected 0", sb.size()); end
        total++; if (ovr_flag !== 1'b0) begin bad++; $display("FAIL mid_ovr_after: got %0b expected 0", ovr_flag); end
        sb_on = 1'b0;
    endtask

    initial begin
        test_reset();
        test_impulse();
        test_dc();
        test_saturation();
        test_overrun();
        test_underrun();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
